idct_scale_sat_pipe: RTL
========================

IDCT_SCALE_SAT_PIPE -- requirements
Module: idct_scale_sat_pipe

Interface
REQ-001 Parameter W_IN, default 42: width of the signed two's-complement sink_real and sink_imag inputs.
REQ-002 Parameter W_OUT, default 24: width of the signed source_real and source_imag outputs; W_OUT < W_IN.
REQ-003 Parameter SHIFT_W, default 5: width of cfg_shift; the legal shift range is 0 to W_IN-W_OUT.
REQ-004 Parameter CNT_W, default 16: width of the per-frame overflow counter.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_sync  in  1  reset, synchronous and active-high.
REQ-007 cfg_shift  in  SHIFT_W  right-shift amount (divide by 2^cfg_shift); captured at the accepted sop beat.
REQ-008 cfg_rnd_mode  in  2  rounding mode; captured at the accepted sop beat.
REQ-009 sink_valid / sink_ready  in / out  1 each  input handshake; a beat transfers when both are high.
REQ-010 sink_sop, sink_eop  in  1 each  frame delimiters, qualified by sink_valid.
REQ-011 sink_real, sink_imag  in  W_IN each  input sample.
REQ-012 fftpts_in  in  12  frame length tag; travels with each beat.
REQ-013 source_valid / source_ready  out / in  1 each  output handshake.
REQ-014 source_sop, source_eop, fftpts_out  out  1, 1, 12  delayed copies of the sink-side sop, eop and fftpts_in.
REQ-015 source_real, source_imag  out  W_OUT each  scaled and saturated sample.
REQ-016 overflow  out  1  high with a valid output beat when real or imag actually clipped.
REQ-017 frame_ovf_cnt  out  CNT_W  number of clipped beats in the last completed frame.
REQ-018 frame_ovf_valid  out  1  one-cycle pulse when frame_ovf_cnt updates.

Function
REQ-019 The datapath shall be a 2-stage pipeline: stage 1 rounds and shifts; stage 2 saturates and registers the outputs.
  - Latency is 2 cycles from sink transfer to source_valid when source_ready is held high.
REQ-020 Backpressure shall use a per-stage valid with the rule "stage may load if it is empty or its successor is loading".
  - sink_ready = !s1_valid | s2_load, where s2_load = !s2_valid | source_ready.
  - Bubbles shall collapse.
  - No beat shall be lost or duplicated.
  - Throughput is 1 beat/cycle when source_ready = 1.
REQ-021 Rounding modes, with s = cfg_shift:
  - 0: truncate (floor).
  - 1: round-half-up (add 2^(s-1), then arithmetic shift).
  - 2: convergent (ties go to even).
  - 3: treated as 1.
  - When s = 0, no offset is added in any mode.
REQ-022 Intermediate arithmetic shall be W_IN+1 bits signed, so the rounding add cannot wrap.
REQ-023 Saturation bounds are -2^(W_OUT-1) and 2^(W_OUT-1)-1; any out-of-range result clamps to the nearer bound.
REQ-024 overflow shall assert only when clamping occurred; a result exactly equal to a bound without clamping shall not raise it.
REQ-025 cfg_shift and cfg_rnd_mode shall be latched on the accepted sop beat and used for every beat until the next sop.
  - Beats before the first sop after reset use shift 0, mode 0.
REQ-026 Frame overflow counter:
  - Increments on each source transfer with overflow = 1.
  - Saturates at 2^CNT_W-1.
  - Clears on the source transfer carrying sop; that beat's own overflow counts.
REQ-027 On the source transfer carrying eop:
  - frame_ovf_cnt shall load the final count, including that beat.
  - frame_ovf_valid shall pulse for exactly one cycle.
  - When sop and eop occur on the same beat, the count is that beat's overflow, 0 or 1.
REQ-028 A sop without a preceding eop shall restart the counter; no frame_ovf_valid is emitted for the aborted frame.
REQ-029 Outputs shall hold stable while source_valid = 1 and source_ready = 0.

Reset
REQ-030 While rst_sync = 1 at a clock edge, the following shall all be 0 on the next edge:
  - all pipeline valids, source_valid, source_sop, source_eop;
  - source_real, source_imag, fftpts_out, overflow;
  - frame_ovf_cnt, frame_ovf_valid, the internal counter and the latched cfg.
REQ-031 sink_ready shall be 1 in the cycle after reset releases.
REQ-032 A reset mid-frame shall discard all in-flight beats; no frame_ovf_valid is emitted for that frame.

Structure
REQ-033 Package idct_pkg shall hold:
  - rounding-mode constants RND_TRUNC = 0, RND_HALFUP = 1, RND_CONV = 2;
  - the default widths.
REQ-034 The single-lane round/shift/saturate logic shall be one sub-module, idct_rnd_sat_lane, instantiated twice (real, imag).
  - It returns the result and a clip flag.
  - The handshake and counter stay in the top level.

Verification
REQ-035 With W_IN=42, W_OUT=24, shift 16, mode 1, source_ready=1:
  - sink_real = 0x18000 -> source_real = 2 after 2 cycles.
  - sink_real = -0x18000 -> -1.
REQ-036 With mode 2, shift 1:
  - inputs 1, 3, -1, -3 -> outputs 0, 2, 0, -2.
  - With mode 0, input -1 -> -1.
REQ-037 With shift 0:
  - sink_real = 2^23 -> 0x7FFFFF, overflow = 1.
  - sink_real = 2^23-1 -> 0x7FFFFF, overflow = 0.
  - sink_imag = -2^23-1 -> 0x800000, overflow = 1.
REQ-038 Drive a 16-beat frame with 3 clipping beats while source_ready toggles randomly:
  - all 16 beats emerge in order with sop/eop intact;
  - frame_ovf_cnt = 3 with a single frame_ovf_valid pulse.
REQ-039 Change cfg_shift from 16 to 8 mid-frame: the frame stays at 16; the next sop frame uses 8.
REQ-040 Assert rst_sync for 1 cycle with 2 beats in flight:
  - no source_valid follows;
  - all outputs are 0;
  - a new frame afterwards produces correct results and count.

Source files
------------

// File: rtl/idct_pkg.sv
// idct_pkg: shared constants for the IDCT output scale/saturate pipeline.
// Holds the default datapath widths and the rounding-mode encoding.
package idct_pkg;

  localparam int DEF_W_IN    = 42;
  localparam int DEF_W_OUT   = 24;
  localparam int DEF_SHIFT_W = 5;
  localparam int DEF_CNT_W   = 16;
  localparam int FFTPTS_W    = 12;

  // Mode 3 behaves like round-half-up; it is named so decoders can list it.
  typedef enum logic [1:0] {
    RND_TRUNC      = 2'd0,
    RND_HALFUP     = 2'd1,
    RND_CONV       = 2'd2,
    RND_HALFUP_ALT = 2'd3
  } rnd_mode_e;

endpackage

// File: rtl/idct_rnd_sat_lane.sv
// idct_rnd_sat_lane: one lane (real or imag) of the scale path.
// Stage 1 adds the rounding offset and arithmetically shifts in a widened
// W_IN+1 bit domain; stage 2 clamps into the W_OUT range and flags clipping.
module idct_rnd_sat_lane
  import idct_pkg::*;
#(
  parameter int W_IN    = DEF_W_IN,
  parameter int W_OUT   = DEF_W_OUT,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic               clk,
  input  logic               rst_sync,
  input  logic               i_s1_load,
  input  logic               i_s2_load,
  input  logic [W_IN-1:0]    i_data,
  input  logic [SHIFT_W-1:0] i_shift,
  input  logic [1:0]         i_mode,
  output logic [W_OUT-1:0]   o_data,
  output logic               o_clip
);

  localparam logic signed [W_IN:0] EXT_ONE = {{W_IN{1'b0}}, 1'b1};
  localparam logic signed [W_IN:0] SAT_MAX = {{(W_IN-W_OUT+2){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_IN:0] SAT_MIN = {{(W_IN-W_OUT+2){1'b1}}, {(W_OUT-1){1'b0}}};

  logic signed [W_IN:0] w_ext;
  logic signed [W_IN:0] w_half;
  logic signed [W_IN:0] w_offset;
  logic signed [W_IN:0] w_sum;
  logic signed [W_IN:0] w_shifted;
  logic                 w_keep_lsb;
  logic signed [W_IN:0] r_s1_val;
  logic [W_OUT-1:0]     w_sat;
  logic                 w_clip;
  logic [W_OUT-1:0]     r_out;
  logic                 r_clip;

  // Pick the rounding offset for the mode, then shift; a zero shift never adds an offset.
  always_comb begin
    w_ext      = {i_data[W_IN-1], i_data};
    w_half     = EXT_ONE << (i_shift - 1'b1);
    w_keep_lsb = |(w_ext & (EXT_ONE << i_shift));
    w_offset   = '0;
    if (i_shift != '0) begin
      case (rnd_mode_e'(i_mode))
        RND_TRUNC: w_offset = '0;
        RND_CONV:  w_offset = w_half - EXT_ONE + {{W_IN{1'b0}}, w_keep_lsb};
        default:   w_offset = w_half;
      endcase
    end
    w_sum     = w_ext + w_offset;
    w_shifted = w_sum >>> i_shift;
  end

  // Stage 1 register: holds the rounded, shifted value of the accepted beat.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_s1_val <= '0;
    end else if (i_s1_load) begin
      r_s1_val <= w_shifted;
    end
  end

  // Clamp to the nearer bound; landing exactly on a bound is not a clip.
  always_comb begin
    w_sat  = r_s1_val[W_OUT-1:0];
    w_clip = 1'b0;
    if (r_s1_val > SAT_MAX) begin
      w_sat  = SAT_MAX[W_OUT-1:0];
      w_clip = 1'b1;
    end else if (r_s1_val < SAT_MIN) begin
      w_sat  = SAT_MIN[W_OUT-1:0];
      w_clip = 1'b1;
    end
  end

  // Stage 2 register: saturated sample and its clip flag.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_out  <= '0;
      r_clip <= 1'b0;
    end else if (i_s2_load) begin
      r_out  <= w_sat;
      r_clip <= w_clip;
    end
  end

  assign o_data = r_out;
  assign o_clip = r_clip;

endmodule

// File: rtl/idct_scale_sat_pipe.sv
// idct_scale_sat_pipe: two-stage scale (round + shift) and saturate pipeline
// for complex IDCT/FFT output samples with valid/ready flow control, per-frame
// configuration latching and a per-frame clipped-beat counter.
module idct_scale_sat_pipe
  import idct_pkg::*;
#(
  parameter int W_IN    = DEF_W_IN,
  parameter int W_OUT   = DEF_W_OUT,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_sync,
  input  logic [SHIFT_W-1:0]  cfg_shift,
  input  logic [1:0]          cfg_rnd_mode,
  input  logic                sink_valid,
  output logic                sink_ready,
  input  logic                sink_sop,
  input  logic                sink_eop,
  input  logic [W_IN-1:0]     sink_real,
  input  logic [W_IN-1:0]     sink_imag,
  input  logic [FFTPTS_W-1:0] fftpts_in,
  output logic                source_valid,
  input  logic                source_ready,
  output logic                source_sop,
  output logic                source_eop,
  output logic [FFTPTS_W-1:0] fftpts_out,
  output logic [W_OUT-1:0]    source_real,
  output logic [W_OUT-1:0]    source_imag,
  output logic                overflow,
  output logic [CNT_W-1:0]    frame_ovf_cnt,
  output logic                frame_ovf_valid
);

  logic                r_s1_valid;
  logic                r_s2_valid;
  logic                w_s1_load;
  logic                w_s2_load;
  logic                w_sink_xfer;
  logic                w_s2_take;
  logic                w_src_xfer;

  logic [SHIFT_W-1:0]  r_cfg_shift;
  logic [1:0]          r_cfg_mode;
  logic [SHIFT_W-1:0]  w_eff_shift;
  logic [1:0]          w_eff_mode;

  logic                r_s1_sop;
  logic                r_s1_eop;
  logic [FFTPTS_W-1:0] r_s1_fft;
  logic                r_s2_sop;
  logic                r_s2_eop;
  logic [FFTPTS_W-1:0] r_s2_fft;

  logic                w_clip_re;
  logic                w_clip_im;
  logic                w_overflow;

  logic [CNT_W-1:0]    r_ovf_cnt;
  logic [CNT_W-1:0]    w_cnt_base;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic                r_frame_valid;

  // A stage may load when it is empty or its successor is loading.
  assign w_s2_load   = !r_s2_valid | source_ready;
  assign w_s1_load   = !r_s1_valid | w_s2_load;
  assign sink_ready  = w_s1_load;
  assign w_sink_xfer = sink_valid & w_s1_load;
  assign w_s2_take   = w_s2_load & r_s1_valid;
  assign w_src_xfer  = r_s2_valid & source_ready;

  // The sop beat itself already uses the configuration presented with it.
  assign w_eff_shift = sink_sop ? cfg_shift    : r_cfg_shift;
  assign w_eff_mode  = sink_sop ? cfg_rnd_mode : r_cfg_mode;

  // Latch the frame configuration on every accepted sop beat.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_cfg_shift <= '0;
      r_cfg_mode  <= '0;
    end else if (w_sink_xfer && sink_sop) begin
      r_cfg_shift <= cfg_shift;
      r_cfg_mode  <= cfg_rnd_mode;
    end
  end

  // Per-stage valid bits; bubbles collapse because an empty stage always loads.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= sink_valid;
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
      end
    end
  end

  // Frame delimiters and length tag travel alongside the data in both stages.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_s1_sop <= 1'b0;
      r_s1_eop <= 1'b0;
      r_s1_fft <= '0;
      r_s2_sop <= 1'b0;
      r_s2_eop <= 1'b0;
      r_s2_fft <= '0;
    end else begin
      if (w_sink_xfer) begin
        r_s1_sop <= sink_sop;
        r_s1_eop <= sink_eop;
        r_s1_fft <= fftpts_in;
      end
      if (w_s2_take) begin
        r_s2_sop <= r_s1_sop;
        r_s2_eop <= r_s1_eop;
        r_s2_fft <= r_s1_fft;
      end
    end
  end

  idct_rnd_sat_lane #(
    .W_IN    (W_IN),
    .W_OUT   (W_OUT),
    .SHIFT_W (SHIFT_W)
  ) u_lane_real (
    .clk       (clk),
    .rst_sync  (rst_sync),
    .i_s1_load (w_sink_xfer),
    .i_s2_load (w_s2_take),
    .i_data    (sink_real),
    .i_shift   (w_eff_shift),
    .i_mode    (w_eff_mode),
    .o_data    (source_real),
    .o_clip    (w_clip_re)
  );

  idct_rnd_sat_lane #(
    .W_IN    (W_IN),
    .W_OUT   (W_OUT),
    .SHIFT_W (SHIFT_W)
  ) u_lane_imag (
    .clk       (clk),
    .rst_sync  (rst_sync),
    .i_s1_load (w_sink_xfer),
    .i_s2_load (w_s2_take),
    .i_data    (sink_imag),
    .i_shift   (w_eff_shift),
    .i_mode    (w_eff_mode),
    .o_data    (source_imag),
    .o_clip    (w_clip_im)
  );

  assign w_overflow   = r_s2_valid & (w_clip_re | w_clip_im);
  assign overflow     = w_overflow;
  assign source_valid = r_s2_valid;
  assign source_sop   = r_s2_sop;
  assign source_eop   = r_s2_eop;
  assign fftpts_out   = r_s2_fft;

  // A sop beat restarts the count but its own clip still counts; saturate at all-ones.
  always_comb begin
    w_cnt_base = r_s2_sop ? '0 : r_ovf_cnt;
    w_cnt_next = w_cnt_base;
    if (w_overflow && (w_cnt_base != {CNT_W{1'b1}})) begin
      w_cnt_next = w_cnt_base + 1'b1;
    end
  end

  // Count clipped beats per frame and publish the total on the eop transfer.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      r_ovf_cnt     <= '0;
      r_frame_cnt   <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      if (w_src_xfer) begin
        r_ovf_cnt <= w_cnt_next;
        if (r_s2_eop) begin
          r_frame_cnt   <= w_cnt_next;
          r_frame_valid <= 1'b1;
        end
      end
    end
  end

  assign frame_ovf_cnt   = r_frame_cnt;
  assign frame_ovf_valid = r_frame_valid;

endmodule
